wb_stream_ram_writer: RTL and testbench
=======================================

// Module: wb_stream_ram_writer
// PURPOSE
// Wishbone master that sits directly upstream of the wishbone single-port RAM slave.
// It takes a valid/ready word stream and writes it to consecutive RAM addresses starting at a programmed base.
// It is used for bulk RAM loading (boot image, packet buffers) without a CPU in the loop.
// Supports optional incrementing-burst CTI, bus error abort and bounded retry.
// PARAMETERS
// Dw          32          data width in bits (matches RAM Dw)
// Aw          10          word address width (matches RAM Aw)
// SELw        Dw/8        byte-select width
// TAGw        3           tag width (tag driven 0)
// CTIw        3           cycle-type width
// BTEw        2           burst-type width
// BURST_MODE  "DISABLED"  "DISABLED" | "ENABLED": classic vs incrementing-burst cycles
// MAX_RETRY   4           rty responses tolerated per word before abort (1..15)
// PORTS
// clk        in   1         clock
// reset      in   1         asynchronous, active-low reset (0 = reset)
// start_i    in   1         launch transfer (sampled only in IDLE)
// base_i     in   Aw        first word address
// len_i      in   Aw+1      word count; 0 = empty job
// s_dat_i    in   Dw        stream data
// s_valid_i  in   1         stream data valid
// s_ready_o  out  1         stream data accepted when valid&ready
// busy_o     out  1         job in progress (state != IDLE)
// done_o     out  1         1-cycle pulse at job end (success or abort)
// err_o      out  1         sticky abort flag; cleared by next accepted start_i
// m_dat_o    out  Dw        wb write data
// m_sel_o    out  SELw      wb byte select
// m_addr_o   out  Aw        wb word address
// m_tag_o    out  TAGw      wb tag
// m_cti_o    out  CTIw      wb cycle type
// m_bte_o    out  BTEw      wb burst type
// m_stb_o    out  1         wb strobe
// m_cyc_o    out  1         wb cycle
// m_we_o     out  1         wb write enable
// m_ack_i    in   1         wb ack
// m_err_i    in   1         wb error
// m_rty_i    in   1         wb retry
// BEHAVIOUR
// - Reset (reset=0, async): state IDLE; all outputs 0; counters, address and data buffer cleared.
// - Reset mid-job: bus released immediately (cyc/stb=0); no done_o pulse; partial writes remain in RAM.
// - States: IDLE, FETCH, BUS, HOLD, FIN.
// - IDLE: on start_i, latch base_i and len_i, clear err_o and retry count.
//   - len_i==0: go to FIN.
//   - len_i!=0: go to FETCH.
// - FETCH: s_ready_o=1. On s_valid_i, capture s_dat_i into a 1-word buffer and go to BUS (1 cycle stream->bus).
// - BUS drive:
//   - cyc=stb=we=1, sel=all ones, addr=current addr, dat=buffer, tag=0, bte=2'b00.
//   - cti=3'b000 when BURST_MODE disabled.
//   - BURST_MODE enabled: cti=3'b010, or 3'b111 on the last word.
//   - All bus outputs are held stable until a response arrives.
// - Response priority in BUS is err > ack > rty.
// - m_err_i: set err_o and go to FIN.
// - m_ack_i: addr<=addr+1 (wraps modulo 2^Aw), remaining<=remaining-1, retry count<=0.
//   - remaining==1: go to FIN.
//   - Burst mode with s_valid_i high in the ack cycle: s_ready_o=1 combinationally, the word is captured, stay in BUS (cyc held).
//   - Otherwise go to FETCH (cyc/stb=0 in FETCH).
// - m_rty_i: retry count+1.
//   - count reaches MAX_RETRY: set err_o and go to FIN.
//   - Otherwise go to HOLD: stb=0, cyc=0 for 1 cycle, then back to BUS with the same addr and data.
// - FIN: done_o=1 for exactly 1 cycle, then IDLE. busy_o=1 in every state except IDLE.
// - start_i outside IDLE is ignored. s_ready_o=0 in IDLE, HOLD and FIN.
// - Stream words arriving after the job ends are not consumed.
// TESTING
// 1. base=0x010, len=4, stream 0xA0..0xA3, slave acks 1 cycle after stb -> RAM[0x010..0x013]=A0..A3, done_o one pulse, err_o=0.
// 2. len=0 start -> no stb asserted; done_o pulses 2 cycles after start; s_ready_o stays 0.
// 3. base=0x3FE (Aw=10), len=3 -> writes at 0x3FE, 0x3FF, 0x000.
// 4. Slave returns rty twice, then ack on word 0 -> stb drops 1 cycle per rty, same addr/data re-presented, single write; with 4 rty -> err_o=1, done_o, job aborted.
// 5. m_err_i on 2nd of 4 words -> err_o=1, done_o pulse, only word 0 written; next start clears err_o.
// 6. BURST_MODE="ENABLED", continuous valid, len=4 -> cyc held across words, cti=010,010,010,111; reset=0 mid-burst -> cyc/stb=0 immediately, no done_o.

Source files
------------

// File: rtl/wb_stream_ram_writer.sv
// Wishbone write master: drains a valid/ready word stream into consecutive RAM
// word addresses from a programmed base, with optional incrementing bursts and bounded retry.
module wb_stream_ram_writer #(
  parameter int unsigned Dw         = 32,
  parameter int unsigned Aw         = 10,
  parameter int unsigned SELw       = Dw / 8,
  parameter int unsigned TAGw       = 3,
  parameter int unsigned CTIw       = 3,
  parameter int unsigned BTEw       = 2,
  parameter string       BURST_MODE = "DISABLED",
  parameter int unsigned MAX_RETRY  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [Aw-1:0]   base_i,
  input  logic [Aw:0]     len_i,
  input  logic [Dw-1:0]   s_dat_i,
  input  logic            s_valid_i,
  output logic            s_ready_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [Dw-1:0]   m_dat_o,
  output logic [SELw-1:0] m_sel_o,
  output logic [Aw-1:0]   m_addr_o,
  output logic [TAGw-1:0] m_tag_o,
  output logic [CTIw-1:0] m_cti_o,
  output logic [BTEw-1:0] m_bte_o,
  output logic            m_stb_o,
  output logic            m_cyc_o,
  output logic            m_we_o,
  input  logic            m_ack_i,
  input  logic            m_err_i,
  input  logic            m_rty_i
);

  localparam int unsigned LenW    = Aw + 1;
  localparam int unsigned RtyW    = 4;
  localparam bit          BurstEn = (BURST_MODE == "ENABLED");

  localparam logic [CTIw-1:0] CtiClassic = CTIw'(3'b000);
  localparam logic [CTIw-1:0] CtiIncr    = CTIw'(3'b010);
  localparam logic [CTIw-1:0] CtiEnd     = CTIw'(3'b111);
  localparam logic [RtyW-1:0] RtyLimit   = RtyW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_BUS   = 3'd2,
    S_HOLD  = 3'd3,
    S_FIN   = 3'd4
  } state_e;

  state_e          state_q;
  logic [Aw-1:0]   addr_q;
  logic [LenW-1:0] rem_q;
  logic [Dw-1:0]   buf_q;
  logic [RtyW-1:0] rty_q;
  logic [CTIw-1:0] cti_q;
  logic            bus_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;

  logic [Aw-1:0]   addr_d;
  logic [LenW-1:0] rem_d;
  logic [RtyW-1:0] rty_d;
  logic            last_word_c;
  logic            chain_c;

  // Cycle type for a word given how many words remain including it.
  function automatic logic [CTIw-1:0] cti_for(input logic [LenW-1:0] remaining);
    if (!BurstEn) begin
      return CtiClassic;
    end
    return (remaining == LenW'(1)) ? CtiEnd : CtiIncr;
  endfunction

  assign addr_d      = addr_q + Aw'(1);
  assign rem_d       = rem_q - LenW'(1);
  assign rty_d       = rty_q + RtyW'(1);
  assign last_word_c = (rem_q == LenW'(1));

  // Burst chaining: the next stream word is taken in the same cycle the current one is acked.
  assign chain_c = BurstEn && (state_q == S_BUS) && !m_err_i && m_ack_i
                   && !last_word_c && s_valid_i;

  assign s_ready_o = (state_q == S_FETCH) || chain_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      rty_q   <= '0;
      cti_q   <= '0;
      bus_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            addr_q <= base_i;
            rem_q  <= len_i;
            err_q  <= 1'b0;
            rty_q  <= '0;
            busy_q <= 1'b1;
            if (len_i == '0) begin
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end

        S_FETCH: begin
          if (s_valid_i) begin
            buf_q   <= s_dat_i;
            cti_q   <= cti_for(rem_q);
            bus_q   <= 1'b1;
            state_q <= S_BUS;
          end
        end

        // Response priority is err, then ack, then rty.
        S_BUS: begin
          if (m_err_i) begin
            err_q   <= 1'b1;
            bus_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end else if (m_ack_i) begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
            rty_q  <= '0;
            if (last_word_c) begin
              bus_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else if (chain_c) begin
              buf_q <= s_dat_i;
              cti_q <= cti_for(rem_d);
            end else begin
              bus_q   <= 1'b0;
              state_q <= S_FETCH;
            end
          end else if (m_rty_i) begin
            rty_q <= rty_d;
            bus_q <= 1'b0;
            if (rty_d == RtyLimit) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else begin
              state_q <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          bus_q   <= 1'b1;
          state_q <= S_BUS;
        end

        S_FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          bus_q   <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign m_dat_o  = buf_q;
  assign m_sel_o  = {SELw{bus_q}};
  assign m_addr_o = addr_q;
  assign m_tag_o  = '0;
  assign m_cti_o  = cti_q;
  assign m_bte_o  = '0;
  assign m_stb_o  = bus_q;
  assign m_cyc_o  = bus_q;
  assign m_we_o   = bus_q;

endmodule

// File: tb/tb_wb_stream_ram_writer.sv
// Bench for wb_stream_ram_writer: classic and burst instances driven by a stream
// source and a scripted wishbone slave; a scoreboard checks every write and done pulse.
module tb_wb_stream_ram_writer;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
    logic [2:0]  cti;
  } wr_t;

  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] exp;
  } chk_t;

  localparam int RespAck = 0;
  localparam int RespRty = 1;
  localparam int RespErr = 2;

  logic clk;
  logic rst_n;

  logic        start  [2];
  logic [9:0]  base   [2];
  logic [10:0] len    [2];
  logic [31:0] sdat   [2];
  logic        svalid [2];
  logic        sready [2];
  logic        busy   [2];
  logic        done   [2];
  logic        err    [2];
  logic [31:0] mdat   [2];
  logic [3:0]  msel   [2];
  logic [9:0]  maddr  [2];
  logic [2:0]  mtag   [2];
  logic [2:0]  mcti   [2];
  logic [1:0]  mbte   [2];
  logic        mstb   [2];
  logic        mcyc   [2];
  logic        mwe    [2];
  logic        mack   [2];
  logic        merr   [2];
  logic        mrty   [2];

  wr_t         exp_wr_q   [$];
  logic        exp_done_q [$];
  chk_t        chk_q      [$];
  logic [31:0] stream_q   [$];
  int          resp_q     [$];

  int n_chk;
  int n_fail;
  int cur;

  int r_cycles, r_stb_rise, r_rdy, r_gaps;

  logic s_hs;
  logic resp_pend;
  int   wcnt;
  int   resp;

  wb_stream_ram_writer #(.BURST_MODE("DISABLED")) u_classic (
    .clk(clk), .reset(rst_n), .start_i(start[0]), .base_i(base[0]), .len_i(len[0]),
    .s_dat_i(sdat[0]), .s_valid_i(svalid[0]), .s_ready_o(sready[0]),
    .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0]),
    .m_dat_o(mdat[0]), .m_sel_o(msel[0]), .m_addr_o(maddr[0]), .m_tag_o(mtag[0]),
    .m_cti_o(mcti[0]), .m_bte_o(mbte[0]), .m_stb_o(mstb[0]), .m_cyc_o(mcyc[0]),
    .m_we_o(mwe[0]), .m_ack_i(mack[0]), .m_err_i(merr[0]), .m_rty_i(mrty[0])
  );

  wb_stream_ram_writer #(.BURST_MODE("ENABLED")) u_burst (
    .clk(clk), .reset(rst_n), .start_i(start[1]), .base_i(base[1]), .len_i(len[1]),
    .s_dat_i(sdat[1]), .s_valid_i(svalid[1]), .s_ready_o(sready[1]),
    .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1]),
    .m_dat_o(mdat[1]), .m_sel_o(msel[1]), .m_addr_o(maddr[1]), .m_tag_o(mtag[1]),
    .m_cti_o(mcti[1]), .m_bte_o(mbte[1]), .m_stb_o(mstb[1]), .m_cyc_o(mcyc[1]),
    .m_we_o(mwe[1]), .m_ack_i(mack[1]), .m_err_i(merr[1]), .m_rty_i(mrty[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Stream source and scripted slave: change inputs on the falling edge.
  always @(negedge clk) begin
    if (s_hs && stream_q.size() != 0) void'(stream_q.pop_front());
    s_hs = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mack[d] = 1'b0;
      mrty[d] = 1'b0;
      merr[d] = 1'b0;
    end
    if (!rst_n) begin
      resp_pend = 1'b0;
      wcnt      = 0;
    end else if (resp_pend) begin
      resp_pend = 1'b0;
      wcnt      = 0;
    end else if (mcyc[cur] && mstb[cur]) begin
      if (wcnt == 1) begin
        resp = (resp_q.size() != 0) ? resp_q.pop_front() : RespAck;
        mack[cur] = (resp == RespAck);
        mrty[cur] = (resp == RespRty);
        merr[cur] = (resp == RespErr);
        resp_pend = 1'b1;
        wcnt      = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
    for (int d = 0; d < 2; d++) begin
      svalid[d] = rst_n && (d == cur) && (stream_q.size() != 0);
      sdat[d]   = svalid[d] ? stream_q[0] : 32'h0;
    end
    #2;
    s_hs = svalid[cur] && sready[cur];
  end

  task automatic compare(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Monitor: drains queued checks and scores every bus write and done pulse.
  always @(negedge clk) begin
    chk_t c;
    wr_t  w;
    #3;
    while (chk_q.size() != 0) begin
      c = chk_q.pop_front();
      compare(c.name, c.act, c.exp);
    end
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (mcyc[d] && mstb[d] && mack[d]) begin
          if (exp_wr_q.size() == 0) begin
            compare("unexpected_write", 64'(exp_wr_q.size()), 64'd1);
          end else begin
            w = exp_wr_q.pop_front();
            compare("wr_addr", 64'(maddr[d]), 64'(w.addr));
            compare("wr_data", 64'(mdat[d]), 64'(w.data));
            compare("wr_cti", 64'(mcti[d]), 64'(w.cti));
            compare("wr_sel_we", 64'({msel[d], mwe[d]}), 64'h1F);
          end
        end else if (mcyc[d] && mstb[d] && mrty[d] && exp_wr_q.size() != 0) begin
          compare("rty_addr", 64'(maddr[d]), 64'(exp_wr_q[0].addr));
          compare("rty_data", 64'(mdat[d]), 64'(exp_wr_q[0].data));
        end
        if (done[d]) begin
          if (exp_done_q.size() == 0) begin
            compare("unexpected_done", 64'(exp_done_q.size()), 64'd1);
          end else begin
            compare("done_err", 64'(err[d]), 64'(exp_done_q.pop_front()));
          end
        end
      end
    end
  end

  task automatic expect_eq(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_q.push_back('{nm, act, exp});
  endtask

  task automatic exp_wr(input logic [9:0] a, input logic [31:0] dt, input logic [2:0] ct);
    exp_wr_q.push_back('{a, dt, ct});
  endtask

  task automatic pulse_start(input int d, input logic [9:0] b, input logic [10:0] l);
    @(negedge clk);
    start[d] = 1'b1;
    base[d]  = b;
    len[d]   = l;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
  endtask

  task automatic run_job(input int d, input logic [9:0] b, input logic [10:0] l);
    bit got;
    bit seen_cyc;
    bit prev_stb;
    got        = 1'b0;
    seen_cyc   = 1'b0;
    prev_stb   = 1'b0;
    r_cycles   = 0;
    r_stb_rise = 0;
    r_rdy      = 0;
    r_gaps     = 0;
    pulse_start(d, b, l);
    expect_eq("busy_at_start", 64'(busy[d]), 64'd1);
    expect_eq("err_at_start", 64'(err[d]), 64'd0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #4;
      r_cycles++;
      if (done[d]) begin
        got = 1'b1;
        break;
      end
      if (mstb[d] && !prev_stb) r_stb_rise++;
      prev_stb = mstb[d];
      if (sready[d]) r_rdy++;
      if (mcyc[d]) seen_cyc = 1'b1;
      else if (seen_cyc) r_gaps++;
    end
    expect_eq("done_timeout", 64'(got), 64'd1);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    cur   = 0;
    rst_n = 1'b0;
    s_hs  = 1'b0;
    resp_pend = 1'b0;
    wcnt  = 0;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;
      base[d]  = '0;
      len[d]   = '0;
    end
    repeat (2) @(negedge clk);
    #4;
    for (int d = 0; d < 2; d++) begin
      expect_eq("reset_outputs",
                64'({mdat[d], maddr[d], mcti[d], busy[d], done[d], err[d],
                     mcyc[d], mstb[d], mwe[d], sready[d]}), 64'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Four-word classic job.
    for (int i = 0; i < 4; i++) begin
      stream_q.push_back(32'hA0 + 32'(i));
      exp_wr(10'h010 + 10'(i), 32'hA0 + 32'(i), 3'b000);
    end
    exp_done_q.push_back(1'b0);
    run_job(0, 10'h010, 11'd4);
    expect_eq("t1_stream_left", 64'(stream_q.size()), 64'd0);

    // Empty job: no bus activity and the waiting word stays put.
    stream_q.push_back(32'h55);
    exp_done_q.push_back(1'b0);
    run_job(0, 10'h000, 11'd0);
    expect_eq("t2_stb_rises", 64'(r_stb_rise), 64'd0);
    expect_eq("t2_ready_cycles", 64'(r_rdy), 64'd0);
    expect_eq("t2_done_latency", 64'(r_cycles <= 2), 64'd1);
    @(negedge clk);
    #4;
    expect_eq("t2_done_one_cycle", 64'({done[0], busy[0]}), 64'd0);
    expect_eq("t2_stream_left", 64'(stream_q.size()), 64'd1);
    stream_q.delete();

    // Address wraps past the top of the word space.
    stream_q.push_back(32'hB0);
    stream_q.push_back(32'hB1);
    stream_q.push_back(32'hB2);
    exp_wr(10'h3FE, 32'hB0, 3'b000);
    exp_wr(10'h3FF, 32'hB1, 3'b000);
    exp_wr(10'h000, 32'hB2, 3'b000);
    exp_done_q.push_back(1'b0);
    run_job(0, 10'h3FE, 11'd3);

    // Two retries then ack: three strobes, one write.
    stream_q.push_back(32'hC0);
    resp_q.push_back(RespRty);
    resp_q.push_back(RespRty);
    exp_wr(10'h020, 32'hC0, 3'b000);
    exp_done_q.push_back(1'b0);
    run_job(0, 10'h020, 11'd1);
    expect_eq("t4_stb_rises", 64'(r_stb_rise), 64'd3);

    // Retry limit reached: abort with error, nothing written.
    stream_q.push_back(32'hD0);
    stream_q.push_back(32'hD1);
    repeat (4) resp_q.push_back(RespRty);
    exp_done_q.push_back(1'b1);
    run_job(0, 10'h030, 11'd2);
    expect_eq("t4b_stb_rises", 64'(r_stb_rise), 64'd4);
    expect_eq("t4b_stream_left", 64'(stream_q.size()), 64'd1);
    stream_q.delete();

    // Bus error on the second word: only word 0 lands, error is sticky.
    for (int i = 0; i < 4; i++) stream_q.push_back(32'hE0 + 32'(i));
    resp_q.push_back(RespAck);
    resp_q.push_back(RespErr);
    exp_wr(10'h040, 32'hE0, 3'b000);
    exp_done_q.push_back(1'b1);
    run_job(0, 10'h040, 11'd4);
    @(negedge clk);
    #4;
    expect_eq("t5_err_sticky", 64'({err[0], busy[0]}), 64'h2);
    expect_eq("t5_stream_left", 64'(stream_q.size()), 64'd2);
    stream_q.delete();
    stream_q.push_back(32'hF0);
    exp_wr(10'h050, 32'hF0, 3'b000);
    exp_done_q.push_back(1'b0);
    run_job(0, 10'h050, 11'd1);

    // Burst instance: continuous stream keeps cyc up across all four words.
    cur = 1;
    for (int i = 0; i < 4; i++) stream_q.push_back(32'h11 + 32'(i));
    exp_wr(10'h100, 32'h11, 3'b010);
    exp_wr(10'h101, 32'h12, 3'b010);
    exp_wr(10'h102, 32'h13, 3'b010);
    exp_wr(10'h103, 32'h14, 3'b111);
    exp_done_q.push_back(1'b0);
    run_job(1, 10'h100, 11'd4);
    expect_eq("t6_cyc_gaps", 64'(r_gaps), 64'd0);
    expect_eq("t6_stb_rises", 64'(r_stb_rise), 64'd1);

    // Reset in the middle of a burst releases the bus with no done pulse.
    for (int i = 0; i < 4; i++) stream_q.push_back(32'h21 + 32'(i));
    exp_wr(10'h200, 32'h21, 3'b010);
    pulse_start(1, 10'h200, 11'd4);
    r_gaps = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #4;
      if (mcyc[1] && mack[1]) begin
        r_gaps = 1;
        break;
      end
    end
    expect_eq("t6r_first_ack_seen", 64'(r_gaps), 64'd1);
    @(posedge clk);
    #1;
    expect_eq("t6r_cyc_before_reset", 64'({mcyc[1], mstb[1]}), 64'h3);
    rst_n = 1'b0;
    #1;
    expect_eq("t6r_bus_released", 64'({mcyc[1], mstb[1], busy[1], done[1]}), 64'd0);
    stream_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    r_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #4;
      if (done[1] || busy[1]) r_cycles++;
    end
    expect_eq("t6r_no_done_after_reset", 64'(r_cycles), 64'd0);

    repeat (2) @(negedge clk);
    expect_eq("writes_outstanding", 64'(exp_wr_q.size()), 64'd0);
    expect_eq("dones_outstanding", 64'(exp_done_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    #5;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
